teclado_varredura: RTL and testbench

Matrix-keypad scanner that drives the 2x2 keypad columns, samples the rows, debounces, and produces the one-hot `tecla[3:0]` vector consumed by the keypad encoder (`codificadorTeclado`) at the front of the vending machine. It sits between the physical keypad pins and the encoder. It guarantees that `tecla` carries at most one asserted bit, and only for a stable, debounced press. It also emits a single-cycle `novo` strobe per accepted press.

---
 rtl/teclado_varredura_if.sv | 11 +
 rtl/teclado_varredura.sv | 135 +++++++++++++
 tb/tb_teclado_varredura.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/teclado_varredura_if.sv
// Keypad pin and decoded-key bundle shared by the scanner and its environment.
// The slave side is the scanner; the master side models the keypad and the encoder.
interface teclado_varredura_if;
    logic [1:0] linhas;
    logic [1:0] colunas;
    logic [3:0] tecla;
    logic       novo;

    modport slave  (input linhas, output colunas, tecla, novo);
    modport master (output linhas, input colunas, tecla, novo);
endinterface

// File: rtl/teclado_varredura.sv
// 2x2 matrix keypad scanner: column sequencing, row sampling and debounce of full scans
// into a one-hot key vector plus a single-cycle press strobe.
module teclado_varredura #(
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_SCANS = 4
) (
    input  logic               clk,
    input  logic               reset,
    teclado_varredura_if.slave kp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEB_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DEB_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        SOLTO,
        CONFIRMA,
        PRESSIONADO,
        LIBERA
    } estado_t;

    logic [DIV_W-1:0] r_div;
    logic             r_col;
    logic [1:0]       r_colunas;
    logic [3:0]       r_raw;
    logic             r_scan_done;
    estado_t          r_estado;
    logic [3:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_tecla;
    logic             r_novo;

    logic             w_slot_end;
    logic             w_raw_onehot;
    logic             w_match;
    logic [CNT_W-1:0] w_cnt_inc;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    assign w_slot_end   = (r_div == DIV_LAST);
    assign w_raw_onehot = is_onehot(r_raw);
    assign w_match      = (r_raw == r_cand);
    assign w_cnt_inc    = r_cnt + CNT_ONE;

    // Rows are sampled on the edge closing each slot so they have the whole slot to settle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div       <= '0;
            r_col       <= 1'b0;
            r_colunas   <= 2'b10;
            r_raw       <= 4'd0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= w_slot_end && r_col;
            if (w_slot_end) begin
                r_div     <= '0;
                r_col     <= ~r_col;
                r_colunas <= r_col ? 2'b10 : 2'b01;
                if (r_col) begin
                    r_raw[3:2] <= ~kp.linhas;
                end else begin
                    r_raw[1:0] <= ~kp.linhas;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado <= SOLTO;
            r_cand   <= 4'd0;
            r_cnt    <= '0;
            r_tecla  <= 4'd0;
            r_novo   <= 1'b0;
        end else begin
            r_novo <= 1'b0;
            if (r_scan_done) begin
                case (r_estado)
                    SOLTO: begin
                        r_tecla <= 4'd0;
                        if (w_raw_onehot) begin
                            r_cand   <= r_raw;
                            r_cnt    <= CNT_ONE;
                            r_estado <= CONFIRMA;
                        end
                    end
                    CONFIRMA: begin
                        if (w_match) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_TOP) begin
                                r_estado <= PRESSIONADO;
                                r_tecla  <= r_cand;
                                r_novo   <= 1'b1;
                            end
                        end else begin
                            r_estado <= SOLTO;
                            r_cnt    <= '0;
                        end
                    end
                    PRESSIONADO: begin
                        r_tecla <= r_cand;
                        if (!w_match) begin
                            r_cnt    <= CNT_ONE;
                            r_estado <= LIBERA;
                        end
                    end
                    LIBERA: begin
                        // A glitch shorter than the release window keeps the key without a new strobe.
                        if (w_match) begin
                            r_estado <= PRESSIONADO;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_TOP) begin
                                r_estado <= SOLTO;
                                r_tecla  <= 4'd0;
                                r_cnt    <= '0;
                            end
                        end
                    end
                    default: r_estado <= SOLTO;
                endcase
            end
        end
    end

    assign kp.colunas = r_colunas;
    assign kp.tecla   = r_tecla;
    assign kp.novo    = r_novo;
endmodule

// File: tb/tb_teclado_varredura.sv
// Scoreboard bench for teclado_varredura: a scan-level keypad model predicts tecla per scan
// and each novo strobe; an independent negedge monitor compares them against the DUT.
module tb_teclado_varredura;
    localparam int SD   = 4;
    localparam int DEB  = 3;
    localparam int SCAN = 2 * SD;

    typedef struct {
        int         when;
        logic [3:0] val;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] keys  = 4'd0;

    teclado_varredura_if kp();

    teclado_varredura #(.SCAN_DIV(SD), .DEB_SCANS(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    // Keypad: a pressed key pulls its row low while its column is driven low.
    assign kp.linhas = (kp.colunas == 2'b01) ? ~keys[3:2] : ~keys[1:0];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t tq[$];
    exp_t nq[$];
    int   base   = 0;
    bit   mon_on = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Scan-level reference state
    logic [3:0] m_held;
    logic [3:0] m_key;
    int         m_run;
    int         m_miss;
    int         scan_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] ec;
        if (mon_on) begin
            if (((cyc - base) % SD) == 2) begin
                ec = ((((cyc - base) / SD) % 2) == 0) ? 2'b10 : 2'b01;
                chk("colunas", 32'(kp.colunas), 32'(ec));
            end
            if (tq.size() > 0 && tq[0].when == cyc) begin
                e = tq.pop_front();
                chk("tecla", 32'(kp.tecla), 32'(e.val));
            end
            if (kp.novo) begin
                if (nq.size() == 0) begin
                    chk("novo_unexpected", 32'(kp.novo), 32'd0);
                end else begin
                    e = nq.pop_front();
                    chk("novo_cycle", 32'(cyc), 32'(e.when));
                    chk("novo_tecla", 32'(kp.tecla), 32'(e.val));
                end
            end else if (nq.size() > 0 && nq[0].when <= cyc) begin
                e = nq.pop_front();
                chk("novo_missing", 32'(kp.novo), 32'd1);
            end
        end
    end

    task automatic model_reset();
        m_held = 4'd0;
        m_key  = 4'd0;
        m_run  = 0;
        m_miss = 0;
        scan_n = 0;
    endtask

    // Present one full scan with pattern k, predict the outcome, then let the scan elapse.
    task automatic scan(input logic [3:0] k);
        exp_t e;
        keys = k;
        scan_n++;
        if (m_held == 4'd0) begin
            if (m_run == 0) begin
                if ($countones(k) == 1) begin
                    m_key = k;
                    m_run = 1;
                end
            end else if (k == m_key) begin
                m_run++;
                if (m_run == DEB) begin
                    m_held = k;
                    m_run  = 0;
                    m_miss = 0;
                    e.when = base + SCAN * scan_n + 1;
                    e.val  = k;
                    nq.push_back(e);
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (k == m_held) begin
                m_miss = 0;
            end else begin
                m_miss++;
                if (m_miss == DEB) m_held = 4'd0;
            end
        end
        e.when = base + SCAN * scan_n + 1;
        e.val  = m_held;
        tq.push_back(e);
        repeat (SCAN) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        model_reset();
        reset  = 1'b1;
        base   = cyc;
        mon_on = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] k;
        int         r;

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_colunas", 32'(kp.colunas), 32'(2'b10));
        chk("reset_tecla", 32'(kp.tecla), 32'd0);
        chk("reset_novo", 32'(kp.novo), 32'd0);
        release_reset();

        for (int i = 0; i < 15; i++) scan(4'b0100);
        scan(4'b0000);
        scan(4'b0100);
        for (int i = 0; i < 5; i++) scan(4'b0000);

        for (int i = 0; i < 10; i++) scan((i % 2 == 0) ? 4'b0010 : 4'b0000);

        for (int i = 0; i < 10; i++) scan(4'b1001);
        for (int i = 0; i < 5; i++) scan(4'b0001);

        k = 4'b0001;
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) k = k;
            else if (r < 8) k = 4'b0001 << $urandom_range(0, 3);
            else if (r == 8) k = 4'b0000;
            else k = 4'($urandom_range(0, 15));
            scan(k);
        end

        for (int i = 0; i < 4; i++) scan(4'b0000);
        for (int i = 0; i < 5; i++) scan(4'b1000);
        repeat (3) @(negedge clk);
        #2;
        reset  = 1'b0;
        mon_on = 1'b0;
        tq.delete();
        nq.delete();
        #1;
        chk("midreset_colunas", 32'(kp.colunas), 32'(2'b10));
        chk("midreset_tecla", 32'(kp.tecla), 32'd0);
        chk("midreset_novo", 32'(kp.novo), 32'd0);
        repeat (2) @(negedge clk);
        release_reset();
        for (int i = 0; i < 5; i++) scan(4'b1000);
        for (int i = 0; i < 4; i++) scan(4'b0000);

        repeat (3) @(negedge clk);
        chk("queues_drained", 32'(tq.size() + nq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
